// File: rtl/key_pkg.sv
// Shared types and helpers for the push-button debounce block.
package key_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_WAIT   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_WAIT = 2'd3
   } key_fsm_e;

   // Convert a duration in milliseconds to clk cycles.
   function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                                input int unsigned ms);
      return clk_hz / 1000 * ms;
   endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key: 2-flop synchroniser, debounce FSM, hold counter and press/release/long pulses.
module key_debounce_ch
   import key_pkg::*;
#(
   parameter int unsigned DB_CNT   = 4,
   parameter int unsigned LONG_CNT = 20
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_n,
   output logic key_state,
   output logic key_press,
   output logic key_release,
   output logic key_long
);

   localparam int unsigned CNT_W = $clog2(LONG_CNT);
   localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CNT - 1);
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CNT - 1);
   localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CNT - 2);

   logic [1:0]       sync_q;
   logic             s;
   key_fsm_e         st;
   logic [CNT_W-1:0] cnt;
   logic             long_seen;

   // Pressed-high view of the synchronised pin.
   assign s = ~sync_q[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q      <= 2'b11;
         st          <= RELEASED;
         cnt         <= '0;
         long_seen   <= 1'b0;
         key_state   <= 1'b0;
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], key_n};
         key_press   <= 1'b0;
         key_release <= 1'b0;
         key_long    <= 1'b0;
         case (st)
            RELEASED: begin
               long_seen <= 1'b0;
               if (s) begin
                  st  <= PRESS_WAIT;
                  cnt <= '0;
               end
            end
            PRESS_WAIT: begin
               if (!s) begin
                  st <= RELEASED;
               end else if (cnt == DB_LAST) begin
                  st        <= PRESSED;
                  cnt       <= '0;
                  key_state <= 1'b1;
                  key_press <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            PRESSED: begin
               if (!s) begin
                  st  <= RELEASE_WAIT;
                  cnt <= '0;
               end else if (cnt != LONG_LAST) begin
                  cnt <= cnt + CNT_W'(1);
                  // Sticky flag keeps a bounce back into PRESSED from re-firing.
                  if (cnt == LONG_PRE && !long_seen) begin
                     key_long  <= 1'b1;
                     long_seen <= 1'b1;
                  end
               end
            end
            RELEASE_WAIT: begin
               if (s) begin
                  st  <= PRESSED;
                  cnt <= '0;
               end else if (cnt == DB_LAST) begin
                  st          <= RELEASED;
                  cnt         <= '0;
                  long_seen   <= 1'b0;
                  key_state   <= 1'b0;
                  key_release <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               st  <= RELEASED;
               cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/key_debounce.sv
// Debounced push-button front end: one independent channel per active-low key.
module key_debounce
   import key_pkg::*;
#(
   parameter int unsigned KEY_W       = 4,
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned DEBOUNCE_MS = 20,
   parameter int unsigned LONG_MS     = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [KEY_W-1:0] pio_key,
   output logic [KEY_W-1:0] key_state,
   output logic [KEY_W-1:0] key_press,
   output logic [KEY_W-1:0] key_release,
   output logic [KEY_W-1:0] key_long
);

   localparam int unsigned DB_CNT   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
   localparam int unsigned LONG_CNT = ms_to_cycles(CLK_HZ, LONG_MS);

   generate
      if (DB_CNT < 2 || LONG_CNT <= DB_CNT) begin : g_bad_params
         $error("key_debounce: need DB_CNT >= 2 and LONG_CNT > DB_CNT");
      end
   endgenerate

   for (genvar i = 0; i < KEY_W; i++) begin : g_ch
      key_debounce_ch #(
         .DB_CNT   (DB_CNT),
         .LONG_CNT (LONG_CNT)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .key_n       (pio_key[i]),
         .key_state   (key_state[i]),
         .key_press   (key_press[i]),
         .key_release (key_release[i]),
         .key_long    (key_long[i])
      );
   end

endmodule
